// File: rtl/tcm_pkg.sv
// Shared widths and helpers for the tightly-coupled memory.
package tcm_pkg;

    localparam int TAG_W   = 11;
    localparam int FETCH_W = 64;
    localparam int DATA_W  = 32;

    // Spread a 32-bit lane mask onto the selected half of a 64-bit word.
    function automatic logic [7:0] lane_mask(input logic [3:0] wr, input logic hi);
        return hi ? {wr, 4'h0} : {4'h0, wr};
    endfunction

endpackage

// File: rtl/tcm_mem_ram.sv
// True dual-port 64-bit RAM: port A read-only, port B byte-write.
module tcm_mem_ram
    import tcm_pkg::*;
#(
    parameter int AW = 14
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic [AW-1:0]      addr_a_i,
    output logic [FETCH_W-1:0] data_a_o,
    input  logic [AW-1:0]      addr_b_i,
    input  logic [7:0]         be_b_i,
    input  logic [FETCH_W-1:0] data_b_i,
    output logic [FETCH_W-1:0] data_b_o
);

    localparam int DEPTH = 1 << AW;

    logic [FETCH_W-1:0] mem_q [0:DEPTH-1];
    logic [FETCH_W-1:0] data_a_q;
    logic [FETCH_W-1:0] data_b_q;

    // Contents survive reset; only the read registers clear.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            data_a_q <= '0;
            data_b_q <= '0;
        end else begin
            data_a_q <= mem_q[addr_a_i];
            data_b_q <= mem_q[addr_b_i];
        end
    end

    always_ff @(posedge clk_i) begin
        for (int i = 0; i < 8; i++) begin
            if (be_b_i[i]) begin
                mem_q[addr_b_i][8*i +: 8] <= data_b_i[8*i +: 8];
            end
        end
    end

    assign data_a_o = data_a_q;
    assign data_b_o = data_b_q;

endmodule

// File: rtl/tcm_mem.sv
// Single-cycle TCM: 64-bit fetch port plus 32-bit tagged data port.
module tcm_mem
    import tcm_pkg::*;
#(
    parameter int MEM_SIZE_BYTES = 131072
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               mem_i_rd_i,
    input  logic               mem_i_flush_i,
    input  logic               mem_i_invalidate_i,
    input  logic [31:0]        mem_i_pc_i,
    output logic               mem_i_accept_o,
    output logic               mem_i_valid_o,
    output logic               mem_i_error_o,
    output logic [FETCH_W-1:0] mem_i_inst_o,
    input  logic [31:0]        mem_d_addr_i,
    input  logic [DATA_W-1:0]  mem_d_data_wr_i,
    input  logic               mem_d_rd_i,
    input  logic [3:0]         mem_d_wr_i,
    input  logic               mem_d_cacheable_i,
    input  logic [TAG_W-1:0]   mem_d_req_tag_i,
    input  logic               mem_d_invalidate_i,
    input  logic               mem_d_writeback_i,
    input  logic               mem_d_flush_i,
    output logic [DATA_W-1:0]  mem_d_data_rd_o,
    output logic               mem_d_accept_o,
    output logic               mem_d_ack_o,
    output logic               mem_d_error_o,
    output logic [TAG_W-1:0]   mem_d_resp_tag_o
);

    localparam int AW  = $clog2(MEM_SIZE_BYTES);
    localparam int WAW = AW - 3;

    logic               i_valid_q, i_valid_d;
    logic               d_ack_q, d_ack_d;
    logic [TAG_W-1:0]   d_tag_q, d_tag_d;
    logic               d_hi_q, d_hi_d;
    logic               d_req;
    logic [7:0]         be;
    logic [FETCH_W-1:0] rd_b;

    assign d_req = mem_d_rd_i | (|mem_d_wr_i) | mem_d_flush_i
                 | mem_d_invalidate_i | mem_d_writeback_i;

    // Writes seen during reset are dropped like any other request.
    assign be = rst_i ? 8'h00 : lane_mask(mem_d_wr_i, mem_d_addr_i[2]);

    tcm_mem_ram #(.AW(WAW)) u_ram (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .addr_a_i (mem_i_pc_i[AW-1:3]),
        .data_a_o (mem_i_inst_o),
        .addr_b_i (mem_d_addr_i[AW-1:3]),
        .be_b_i   (be),
        .data_b_i ({mem_d_data_wr_i, mem_d_data_wr_i}),
        .data_b_o (rd_b)
    );

    always_comb begin
        i_valid_d = mem_i_rd_i;
        d_ack_d   = d_req;
        d_tag_d   = mem_d_req_tag_i;
        d_hi_d    = mem_d_addr_i[2];
        if (rst_i) begin
            i_valid_d = 1'b0;
            d_ack_d   = 1'b0;
            d_tag_d   = '0;
            d_hi_d    = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        i_valid_q <= i_valid_d;
        d_ack_q   <= d_ack_d;
        d_tag_q   <= d_tag_d;
        d_hi_q    <= d_hi_d;
    end

    assign mem_i_accept_o   = 1'b1;
    assign mem_i_error_o    = 1'b0;
    assign mem_i_valid_o    = i_valid_q;
    assign mem_d_accept_o   = 1'b1;
    assign mem_d_error_o    = 1'b0;
    assign mem_d_ack_o      = d_ack_q;
    assign mem_d_resp_tag_o = d_tag_q;
    assign mem_d_data_rd_o  = d_hi_q ? rd_b[63:32] : rd_b[31:0];

    logic unused_ok;
    assign unused_ok = ^{mem_i_flush_i, mem_i_invalidate_i,
                         mem_i_pc_i[31:AW], mem_i_pc_i[2:0],
                         mem_d_addr_i[31:AW], mem_d_addr_i[1:0],
                         mem_d_cacheable_i};

    task write(input logic [31:0] addr, input logic [7:0] data);
        u_ram.mem_q[addr[AW-1:3]][{addr[2:0], 3'b000} +: 8] = data;
    endtask

endmodule

// File: tb/tb_tcm_mem.sv
// Directed self-checking bench for tcm_mem.
module tb_tcm_mem;

    logic        clk = 1'b0;
    logic        rst;
    logic        i_rd, i_flush, i_inv;
    logic [31:0] i_pc;
    logic        i_accept, i_valid, i_error;
    logic [63:0] i_inst;
    logic [31:0] d_addr, d_wdata, d_rdata;
    logic        d_rd, d_cache, d_inv, d_wb, d_flush;
    logic [3:0]  d_wr;
    logic [10:0] d_tag, d_rtag;
    logic        d_accept, d_ack, d_error;

    int compared   = 0;
    int mismatched = 0;

    always #5 clk = ~clk;

    tcm_mem dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .mem_i_rd_i         (i_rd),
        .mem_i_flush_i      (i_flush),
        .mem_i_invalidate_i (i_inv),
        .mem_i_pc_i         (i_pc),
        .mem_i_accept_o     (i_accept),
        .mem_i_valid_o      (i_valid),
        .mem_i_error_o      (i_error),
        .mem_i_inst_o       (i_inst),
        .mem_d_addr_i       (d_addr),
        .mem_d_data_wr_i    (d_wdata),
        .mem_d_rd_i         (d_rd),
        .mem_d_wr_i         (d_wr),
        .mem_d_cacheable_i  (d_cache),
        .mem_d_req_tag_i    (d_tag),
        .mem_d_invalidate_i (d_inv),
        .mem_d_writeback_i  (d_wb),
        .mem_d_flush_i      (d_flush),
        .mem_d_data_rd_o    (d_rdata),
        .mem_d_accept_o     (d_accept),
        .mem_d_ack_o        (d_ack),
        .mem_d_error_o      (d_error),
        .mem_d_resp_tag_o   (d_rtag)
    );

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        i_rd = 0; i_flush = 0; i_inv = 0; i_pc = '0;
        d_addr = '0; d_wdata = '0; d_rd = 0; d_wr = '0;
        d_cache = 0; d_inv = 0; d_wb = 0; d_flush = 0; d_tag = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle();
        rst = 1'b1;
        dut.write(32'h0, 8'h13);
        dut.write(32'h1, 8'h00);
        dut.write(32'h2, 8'h00);
        dut.write(32'h3, 8'h00);
        dut.write(32'h4, 8'h6F);
        dut.write(32'h5, 8'h00);
        dut.write(32'h6, 8'h00);
        dut.write(32'h7, 8'h00);
        for (int b = 0; b < 8; b++) dut.write(32'h100 + b, 8'h00);

        // reset with requests presented
        i_rd = 1; d_rd = 1; d_addr = 32'h0; d_tag = 11'h123;
        tick();
        tick();
        check("rst_valid", {63'b0, i_valid}, 64'd0);
        check("rst_ack", {63'b0, d_ack}, 64'd0);
        check("rst_tag", {53'b0, d_rtag}, 64'd0);
        check("rst_inst", i_inst, 64'd0);
        check("rst_rdata", {32'b0, d_rdata}, 64'd0);
        check("const", {60'b0, i_accept, d_accept, i_error, d_error}, 64'hC);

        rst = 1'b0;
        idle();
        i_rd = 1; i_pc = 32'h8000_0000;
        tick();
        check("fetch0_valid", {63'b0, i_valid}, 64'd1);
        check("fetch0_inst", i_inst, 64'h0000006F_00000013);

        idle();
        tick();
        check("idle_valid", {63'b0, i_valid}, 64'd0);
        check("idle_ack", {63'b0, d_ack}, 64'd0);

        idle();
        d_wr = 4'hF; d_addr = 32'h8000_0104;
        d_wdata = 32'hDEADBEEF; d_tag = 11'h155;
        tick();
        check("wr_ack", {63'b0, d_ack}, 64'd1);
        check("wr_tag", {53'b0, d_rtag}, 64'h155);

        idle();
        d_rd = 1; d_addr = 32'h8000_0104; d_tag = 11'h2AA;
        tick();
        check("rd_ack", {63'b0, d_ack}, 64'd1);
        check("rd_tag", {53'b0, d_rtag}, 64'h2AA);
        check("rd_data", {32'b0, d_rdata}, 64'hDEADBEEF);

        idle();
        d_wr = 4'b0010; d_addr = 32'h8000_0104; d_wdata = 32'h0000AB00;
        tick();
        idle();
        d_rd = 1; d_addr = 32'h8000_0104; d_tag = 11'h001;
        tick();
        check("byte_wr", {32'b0, d_rdata}, 64'hDEADABEF);

        idle();
        i_rd = 1; i_pc = 32'h8000_0100;
        d_wr = 4'hF; d_addr = 32'h8000_0100; d_wdata = 32'h12345678;
        tick();
        check("coll_inst", i_inst, 64'hDEADABEF_00000000);
        check("coll_ack", {63'b0, d_ack}, 64'd1);

        idle();
        i_rd = 1; i_pc = 32'h8000_0100;
        tick();
        check("after_coll", i_inst, 64'hDEADABEF_12345678);

        idle();
        d_rd = 1; d_wr = 4'hF; d_addr = 32'h8000_0100;
        d_wdata = 32'hCAFEF00D;
        tick();
        check("rdwr_old", {32'b0, d_rdata}, 64'h12345678);
        idle();
        d_rd = 1; d_addr = 32'h8000_0100;
        tick();
        check("rdwr_new", {32'b0, d_rdata}, 64'hCAFEF00D);

        idle();
        i_rd = 1; i_pc = 32'h8000_0000;
        tick();
        check("b2b0_valid", {63'b0, i_valid}, 64'd1);
        check("b2b0_inst", i_inst, 64'h0000006F_00000013);
        i_pc = 32'h8000_0104;
        tick();
        check("b2b1_valid", {63'b0, i_valid}, 64'd1);
        check("b2b1_inst", i_inst, 64'hDEADABEF_CAFEF00D);

        idle();
        d_flush = 1; d_addr = 32'h8000_0104; d_wdata = 32'hFFFFFFFF;
        d_tag = 11'h7FF;
        tick();
        check("flush_ack", {63'b0, d_ack}, 64'd1);
        check("flush_tag", {53'b0, d_rtag}, 64'h7FF);
        idle();
        d_rd = 1; d_addr = 32'h8000_0104;
        tick();
        check("flush_mem", {32'b0, d_rdata}, 64'hDEADABEF);

        idle();
        rst = 1'b1;
        i_rd = 1; i_pc = 32'h0;
        d_rd = 1; d_addr = 32'h8000_0104; d_tag = 11'h003;
        tick();
        check("rst2_valid", {63'b0, i_valid}, 64'd0);
        check("rst2_ack", {63'b0, d_ack}, 64'd0);
        check("rst2_tag", {53'b0, d_rtag}, 64'd0);
        check("rst2_inst", i_inst, 64'd0);

        rst = 1'b0;
        idle();
        i_rd = 1; i_pc = 32'h0000_0000;
        d_rd = 1; d_addr = 32'h0000_0104; d_tag = 11'h001;
        tick();
        check("keep_rdata", {32'b0, d_rdata}, 64'hDEADABEF);
        check("keep_inst", i_inst, 64'h0000006F_00000013);
        check("keep_tag", {53'b0, d_rtag}, 64'h001);

        idle();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
